prog_signal_delay: RTL and testbench
====================================

Name: prog_signal_delay

Overview:
- Runtime-programmable, multi-channel delay line; the parametrised successor to the fixed compile-time shift-register delay used across the datapath.
- Delays NUM_CH parallel DATAWIDTH lanes by 1..MAX_DELAY enabled cycles, selected at run time.
- Carries a per-sample valid bit and flushes cleanly on delay change.
- Sits between stage outputs and downstream consumers that need software-tunable alignment.

Parameters:
- DATAWIDTH, 32, bits per channel.
- NUM_CH, 1, number of parallel lanes sharing one delay setting.
- MAX_DELAY, 16, deepest delay and ring depth (>=2).
- INIT_DELAY, 2, delay in force after reset (1..MAX_DELAY).
- DLY_W, derived localparam = clog2(MAX_DELAY+1), delay field width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  advance enable; the buffer shifts only when high.
- delay_load  in  1  one-cycle strobe that latches delay_sel.
- delay_sel  in  DLY_W  requested delay in enabled cycles.
- pre_valid  in  1  qualifies pre_signal.
- pre_signal  in  NUM_CH*DATAWIDTH  input samples, channel 0 in the LSBs.
- signal  out  NUM_CH*DATAWIDTH  delayed samples.
- signal_valid  out  1  delayed pre_valid, masked during fill.
- cur_delay  out  DLY_W  delay currently in force.
- busy  out  1  high while filling after a reset or a load.
- load_err  out  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- Reset (rst_n low at a clk edge):
  - all ring data and valid bits = 0; wr_ptr = 0; fill_cnt = 0.
  - cur_delay = INIT_DELAY; state = FILL.
  - signal = 0, signal_valid = 0, busy = 1, load_err = 0.
  - Reset mid-operation discards all contents.
- Storage: ring of MAX_DELAY entries, each {valid, NUM_CH*DATAWIDTH}.
- Write side: when en is high, write {pre_valid, pre_signal} at wr_ptr. wr_ptr increments and wraps MAX_DELAY-1 -> 0.
- Read side: combinational from regs at (wr_ptr - cur_delay) mod MAX_DELAY.
  - A sample written on enabled cycle k appears on signal after exactly cur_delay further enabled cycles.
  - With en held high and D=2, the output matches the fixed two-cycle delay.
- Delay load, on a cycle with delay_load high:
  - cur_delay = clamp(delay_sel): 0 maps to 1; values > MAX_DELAY map to MAX_DELAY.
  - All valid bits are cleared (flush); data bits are left unchanged.
  - fill_cnt = 0, state = FILL.
  - If en is also high that cycle, the sample is written after the flush and counts as fill sample 1.
- FSM:
  - FILL: busy = 1, signal_valid = 0. fill_cnt increments per enabled cycle. Go to RUN when fill_cnt reaches cur_delay.
  - RUN: busy = 0, signal_valid = stored valid bit at the read pointer.
  - delay_load in any state goes to FILL.
- en low: ring, pointers, fill_cnt and outputs hold.
- delay_load while en is low: the flush still occurs immediately.
- Simultaneous rst_n low and delay_load: reset wins.

Optional Feature:
- Macro: SIGNAL_DELAY_LOAD_ERR_EN.
- Defined: load_err is set on any delay_load with delay_sel = 0 or delay_sel > MAX_DELAY. It stays set until reset. Clamping still applies.
- Undefined: load_err is tied 0 and no check logic is synthesised. Clamping behaviour is unchanged.

Decomposition:
- Package signal_delay_pkg holds:
  - state enum {FILL, RUN};
  - a clog2 function;
  - a clamp_delay function for the shared clamp rule.
- One sub-module, delay_ring_mem, holds the ring storage, wr_ptr, the wrap arithmetic and the read mux, with a flush input.
- The top level holds the FSM, fill counter, cur_delay and error flag.

Test Plan:
- Reset, then en = 1 and pre_valid = 1 with pre_signal = 1,2,3,... at INIT_DELAY = 2:
  - signal_valid is low for 2 cycles, then signal = 1,2,3...;
  - busy drops after 2 enabled cycles.
- delay_load with delay_sel = 5 mid-stream:
  - valid drops the next cycle;
  - after 5 enabled cycles, signal shows the first post-load sample with valid = 1.
- en toggled 1,0,1,0 at D = 3:
  - output advances only on enabled cycles;
  - a sample emerges after exactly 3 enabled cycles; held values are stable while en = 0.
- delay_sel = 0, then delay_sel = MAX_DELAY+3:
  - cur_delay reads 1, then MAX_DELAY;
  - load_err = 1 only with SIGNAL_DELAY_LOAD_ERR_EN defined.
- D = MAX_DELAY with NUM_CH = 4 and distinct per-lane ramps, run for more than 3*MAX_DELAY cycles:
  - wr_ptr wraps correctly and lanes never swap.
- rst_n low asserted while in RUN with delay_load high on the same cycle:
  - all outputs are 0 and busy = 1;
  - cur_delay = INIT_DELAY, not delay_sel.

Source files
------------

// File: rtl/signal_delay_pkg.sv
// Shared types and helpers for the programmable delay line: FSM state,
// constant clog2, and the delay clamp rule.
package signal_delay_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Requests of 0 collapse to the shortest delay; oversize requests saturate.
   function automatic int clamp_delay(input int sel, input int max_d);
      if (sel < 1)
         return 1;
      else if (sel > max_d)
         return max_d;
      return sel;
   endfunction

endpackage

// File: rtl/delay_ring_mem.sv
// Ring storage for the delay line. It holds a write pointer and {valid, data} entries,
// and reads combinationally at a tap rd_delay entries behind the write pointer.
module delay_ring_mem
   import signal_delay_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   parameter  int DLY_W = 5,
   localparam int PTR_W = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [DLY_W-1:0] rd_delay,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   int               rd_sum;

   // The flush clears only the valid bits. A write on the same edge lands after
   // the flush, so its valid bit is kept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
         valid_q <= '0;
         wr_ptr  <= '0;
      end else begin
         if (flush) valid_q <= '0;
         if (en) begin
            data_q[wr_ptr]  <= wr_data;
            valid_q[wr_ptr] <= wr_valid;
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
      end
   end

   always_comb begin
      rd_sum = int'(wr_ptr) + DEPTH - int'(rd_delay);
      if (rd_sum >= DEPTH) rd_sum = rd_sum - DEPTH;
      rd_ptr = PTR_W'(rd_sum);
   end

   assign rd_data  = data_q[rd_ptr];
   assign rd_valid = valid_q[rd_ptr];

endmodule

// File: rtl/prog_signal_delay.sv
// Runtime-programmable multi-lane delay line with fill masking on reset and on delay load.
// Optional sticky out-of-range flag: define SIGNAL_DELAY_LOAD_ERR_EN.
//
// state | meaning
// FILL  | ring refilling after reset/load; busy=1, signal_valid=0
// RUN   | fill_cnt reached cur_delay; signal_valid follows stored valid
module prog_signal_delay
   import signal_delay_pkg::*;
#(
   parameter  int DATAWIDTH  = 32,
   parameter  int NUM_CH     = 1,
   parameter  int MAX_DELAY  = 16,
   parameter  int INIT_DELAY = 2,
   localparam int DLY_W      = clog2(MAX_DELAY + 1),
   localparam int W          = NUM_CH * DATAWIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             delay_load,
   input  logic [DLY_W-1:0] delay_sel,
   input  logic             pre_valid,
   input  logic [W-1:0]     pre_signal,
   output logic [W-1:0]     signal,
   output logic             signal_valid,
   output logic [DLY_W-1:0] cur_delay,
   output logic             busy,
   output logic             load_err
);

   state_t           state_q, state_d;
   logic [DLY_W-1:0] fill_q, fill_d;
   logic [DLY_W-1:0] cur_q, cur_d;
   logic [DLY_W-1:0] sel_clamped;
   logic             flush;
   logic             rd_valid;

   assign sel_clamped = DLY_W'(clamp_delay(int'(delay_sel), MAX_DELAY));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FILL;
         fill_q  <= '0;
         cur_q   <= DLY_W'(INIT_DELAY);
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cur_q   <= cur_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      cur_d   = cur_q;
      flush   = 1'b0;
      if (delay_load) begin
         flush = 1'b1;
         cur_d = sel_clamped;
         // A sample written on the load cycle is the first fill sample.
         fill_d  = en ? DLY_W'(1) : '0;
         state_d = (en && sel_clamped == DLY_W'(1)) ? RUN : FILL;
      end else if (en && state_q == FILL) begin
         fill_d = fill_q + DLY_W'(1);
         if (fill_d >= cur_q) state_d = RUN;
      end
   end

   delay_ring_mem #(
      .WIDTH (W),
      .DEPTH (MAX_DELAY),
      .DLY_W (DLY_W)
   ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .flush    (flush),
      .wr_valid (pre_valid),
      .wr_data  (pre_signal),
      .rd_delay (cur_q),
      .rd_valid (rd_valid),
      .rd_data  (signal)
   );

   assign signal_valid = (state_q == RUN) && rd_valid;
   assign busy         = (state_q == FILL);
   assign cur_delay    = cur_q;

`ifdef SIGNAL_DELAY_LOAD_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (delay_load && (delay_sel == '0 || int'(delay_sel) > MAX_DELAY))
         err_q <= 1'b1;
   end

   assign load_err = err_q;
`else
   assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_signal_delay.sv
// Directed bench for prog_signal_delay with a write-history model checked every cycle.
module tb_prog_signal_delay;

   localparam int DW    = 16;
   localparam int NCH   = 4;
   localparam int MAXD  = 16;
   localparam int INITD = 2;
   localparam int DLY_W = 5;
   localparam int W     = DW * NCH;
`ifdef SIGNAL_DELAY_LOAD_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             delay_load = 1'b0;
   logic [DLY_W-1:0] delay_sel = '0;
   logic             pre_valid = 1'b0;
   logic [W-1:0]     pre_signal = '0;
   logic [W-1:0]     signal;
   logic             signal_valid;
   logic [DLY_W-1:0] cur_delay;
   logic             busy;
   logic             load_err;

   always #5 clk = ~clk;

   prog_signal_delay #(
      .DATAWIDTH  (DW),
      .NUM_CH     (NCH),
      .MAX_DELAY  (MAXD),
      .INIT_DELAY (INITD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .delay_load   (delay_load),
      .delay_sel    (delay_sel),
      .pre_valid    (pre_valid),
      .pre_signal   (pre_signal),
      .signal       (signal),
      .signal_valid (signal_valid),
      .cur_delay    (cur_delay),
      .busy         (busy),
      .load_err     (load_err)
   );

   int checks   = 0;
   int failures = 0;

   // Model: every enabled write since reset, writes since the last flush, delay in force.
   logic [W-1:0] dq[$];
   bit           vq[$];
   int           m_n = 0;
   int           m_d = INITD;
   bit           m_err = 1'b0;
   bit           armed = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] lanes(input int k);
      logic [W-1:0] r;
      r = '0;
      for (int l = 0; l < NCH; l++) r[l*DW +: DW] = DW'(k + l * 256);
      return r;
   endfunction

   task automatic step(input bit r, input bit e, input bit ld, input int sel,
                       input bit pv, input logic [W-1:0] d);
      rst_n      = r;
      en         = e;
      delay_load = ld;
      delay_sel  = DLY_W'(sel);
      pre_valid  = pv;
      pre_signal = d;
      @(posedge clk);
      if (!r) begin
         dq.delete();
         vq.delete();
         m_n   = 0;
         m_d   = INITD;
         m_err = 1'b0;
         armed = 1'b1;
      end else begin
         if (ld) begin
            m_d = (sel < 1) ? 1 : ((sel > MAXD) ? MAXD : sel);
            m_n = 0;
            if (ERR_EN && (sel < 1 || sel > MAXD)) m_err = 1'b1;
         end
         if (e) begin
            dq.push_back(d);
            vq.push_back(pv);
            m_n++;
         end
      end
      #1;
   endtask

   always @(negedge clk) begin : cmp
      int           sz;
      logic [W-1:0] es;
      bit           ev;
      if (armed) begin
         sz = dq.size();
         es = (sz >= m_d) ? dq[sz-m_d] : '0;
         ev = (m_n >= m_d) && (sz >= m_d) && vq[sz-m_d];
         chk("model_busy", 64'(busy), 64'(m_n < m_d));
         chk("model_valid", 64'(signal_valid), 64'(ev));
         chk("model_signal", 64'(signal), 64'(es));
         chk("model_cur_delay", 64'(cur_delay), 64'(m_d));
         chk("model_load_err", 64'(load_err), 64'(m_err));
      end
   end

   initial begin
      step(0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      chk("rst_cur_delay", 64'(cur_delay), 64'd2);
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_signal", 64'(signal), 64'd0);
      chk("rst_valid", 64'(signal_valid), 64'd0);
      chk("rst_load_err", 64'(load_err), 64'd0);

      for (int k = 1; k <= 10; k++) begin
         step(1, 1, 0, 0, 1, lanes(k));
         if (k == 1) begin
            chk("fill_busy_k1", 64'(busy), 64'd1);
            chk("fill_valid_k1", 64'(signal_valid), 64'd0);
         end
         if (k == 2) begin
            chk("d2_first_lane0", 64'(signal[15:0]), 64'd1);
            chk("d2_first_valid", 64'(signal_valid), 64'd1);
            chk("d2_busy_drop", 64'(busy), 64'd0);
         end
      end

      step(1, 1, 1, 5, 1, lanes(11));
      chk("load5_valid_drop", 64'(signal_valid), 64'd0);
      chk("load5_busy", 64'(busy), 64'd1);
      chk("load5_cur_delay", 64'(cur_delay), 64'd5);
      for (int k = 12; k <= 15; k++) begin
         step(1, 1, 0, 0, 1, lanes(k));
         if (k == 14) chk("load5_still_fill", 64'(signal_valid), 64'd0);
      end
      chk("load5_lane0", 64'(signal[15:0]), 64'd11);
      chk("load5_lane1", 64'(signal[31:16]), 64'h010B);
      chk("load5_valid", 64'(signal_valid), 64'd1);

      step(1, 0, 1, 3, 1, lanes(50));
      chk("load3_cur_delay", 64'(cur_delay), 64'd3);
      chk("load3_busy", 64'(busy), 64'd1);
      step(1, 1, 0, 0, 1, lanes(20));
      step(1, 0, 0, 0, 1, lanes(99));
      step(1, 1, 0, 0, 1, lanes(21));
      step(1, 0, 0, 0, 1, lanes(99));
      step(1, 1, 0, 0, 1, lanes(22));
      chk("en_tog_lane0", 64'(signal[15:0]), 64'd20);
      chk("en_tog_valid", 64'(signal_valid), 64'd1);
      step(1, 0, 0, 0, 1, lanes(98));
      chk("en_hold_lane0", 64'(signal[15:0]), 64'd20);
      chk("en_hold_valid", 64'(signal_valid), 64'd1);

      step(1, 1, 1, 0, 1, lanes(30));
      chk("sel0_cur_delay", 64'(cur_delay), 64'd1);
      chk("sel0_load_err", 64'(load_err), 64'(ERR_EN));
      chk("sel0_busy", 64'(busy), 64'd0);
      chk("sel0_lane0", 64'(signal[15:0]), 64'd30);
      step(1, 0, 1, MAXD + 3, 1, lanes(0));
      chk("selbig_cur_delay", 64'(cur_delay), 64'd16);
      chk("selbig_load_err", 64'(load_err), 64'(ERR_EN));

      for (int k = 100; k < 160; k++)
         step(1, (k % 9) != 0, 0, 0, (k % 5) != 0, lanes(k));

      step(0, 1, 1, 7, 1, lanes(200));
      chk("rstld_cur_delay", 64'(cur_delay), 64'd2);
      chk("rstld_busy", 64'(busy), 64'd1);
      chk("rstld_signal", 64'(signal), 64'd0);
      chk("rstld_valid", 64'(signal_valid), 64'd0);
      chk("rstld_load_err", 64'(load_err), 64'd0);
      for (int k = 201; k <= 204; k++) begin
         step(1, 1, 0, 0, 1, lanes(k));
         if (k == 202) chk("post_rst_lane3", 64'(signal[63:48]), 64'h03C9);
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
